// File: rtl/dmem_write_buffer.sv
// rtl/dmem_write_buffer.sv - FIFO store buffer between the processor data port and dmem
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   p_addr .. p_data_in     processor data-memory request (store/load, size, sign)
//   p_data_out              load data returned to the processor
//   stall                   combinational; processor holds PC and request while high
//   m_addr .. m_data_in     dmem request (drains and non-conflicting loads)
//   m_data_out              dmem combinational read data
//   occupancy, empty        buffered store count / no stores pending
//   stat_stall_cycles       stall cycle counter (WBUF_STATS_EN), else 0
//   stat_forwards           forwarded load counter (WBUF_STATS_EN), else 0
// Optional feature macro: WBUF_STATS_EN

module dmem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      p_addr,
  input  logic             p_write_enable,
  input  logic             p_mem_read,
  input  logic             p_byte,
  input  logic             p_half_word,
  input  logic             p_sign_extend,
  input  logic [31:0]      p_data_in,
  output logic [31:0]      p_data_out,
  output logic             stall,
  output logic [31:0]      m_addr,
  output logic             m_write_enable,
  output logic             m_byte,
  output logic             m_half_word,
  output logic             m_sign_extend,
  output logic [31:0]      m_data_in,
  input  logic [31:0]      m_data_out,
  output logic [CNT_W-1:0] occupancy,
  output logic             empty,
  output logic [31:0]      stat_stall_cycles,
  output logic [31:0]      stat_forwards
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic             ent_byte [DEPTH];
  logic             ent_half [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             is_store;
  logic             is_load;
  logic             full;
  logic             hit;
  logic             hit_word;
  logic [31:0]      hit_addr;
  logic [31:0]      hit_data;
  logic [PTR_W-1:0] idx;
  logic             forward;
  logic             stall_int;
  logic             drain;
  logic             enq;

  // Reset masks every request so the port stays quiet and nothing drains that cycle.
  assign is_store = !reset && p_write_enable;
  assign is_load  = !reset && p_mem_read && !p_write_enable;
  assign full     = (count == CNT_W'(DEPTH));

  // Scan oldest to newest so the last match left standing is the newest overlapping entry.
  always_comb begin
    hit      = 1'b0;
    hit_word = 1'b0;
    hit_addr = '0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (ent_addr[idx][31:2] == p_addr[31:2])) begin
        hit      = 1'b1;
        hit_word = !ent_byte[idx] && !ent_half[idx];
        hit_addr = ent_addr[idx];
        hit_data = ent_data[idx];
      end
    end
  end

  assign forward   = is_load && hit && hit_word && !p_byte && !p_half_word && (hit_addr == p_addr);
  assign stall_int = (is_load && hit && !forward) || (is_store && full);
  assign drain     = stall_int || (!reset && !p_write_enable && !p_mem_read && (count != '0));
  assign enq       = is_store && !full;

  assign stall     = stall_int;
  assign occupancy = count;
  assign empty     = (count == '0);

  always_comb begin
    m_addr         = '0;
    m_write_enable = 1'b0;
    m_byte         = 1'b0;
    m_half_word    = 1'b0;
    m_sign_extend  = 1'b0;
    m_data_in      = '0;
    p_data_out     = '0;
    if (drain) begin
      m_addr         = ent_addr[head];
      m_data_in      = ent_data[head];
      m_byte         = ent_byte[head];
      m_half_word    = ent_half[head];
      m_write_enable = 1'b1;
    end else if (is_load && !hit) begin
      m_addr        = p_addr;
      m_data_in     = p_data_in;
      m_byte        = p_byte;
      m_half_word   = p_half_word;
      m_sign_extend = p_sign_extend;
      p_data_out    = m_data_out;
    end else if (forward) begin
      p_data_out = hit_data;
    end
  end

  // Enqueue and drain are mutually exclusive by construction of the arbitration above.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (enq) begin
      tail  <= tail + 1'b1;
      count <= count + 1'b1;
    end else if (drain) begin
      head  <= head + 1'b1;
      count <= count - 1'b1;
    end
  end

  // Entry payload needs no reset: it is only ever read under count.
  always_ff @(posedge clock) begin
    if (enq) begin
      ent_addr[tail] <= p_addr;
      ent_data[tail] <= p_data_in;
      ent_byte[tail] <= p_byte;
      ent_half[tail] <= p_half_word;
    end
  end

`ifdef WBUF_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall_int) stall_cnt <= stall_cnt + 32'd1;
      if (forward)   fwd_cnt   <= fwd_cnt + 32'd1;
    end
  end

  assign stat_stall_cycles = stall_cnt;
  assign stat_forwards     = fwd_cnt;
`else
  assign stat_stall_cycles = '0;
  assign stat_forwards     = '0;
`endif

endmodule
